// File: rtl/potential_update_scheduler_pkg.sv
// potential_update_scheduler_pkg: shared FSM encoding, reset constants and float helpers
// Contents: state_t (scheduler states), DEF_NUM_NEURONS / DEF_ID_W defaults,
//   THRESH_RESET (1.0f), fp_add (single-precision add, round-to-nearest-even,
//   subnormals flushed to zero), fp_ge (ordered single-precision compare).
package potential_update_scheduler_pkg;
   localparam int DEF_NUM_NEURONS = 4;
   localparam int DEF_ID_W = 2;
   localparam logic [31:0] THRESH_RESET = 32'h3F80_0000;
   typedef enum logic [2:0] {IDLE, WAIT_EVT, ISSUE, CAPTURE, SPIKE_OUT, DONE} state_t;
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [26:0] mx, my, ys;
      logic [27:0] s;
      logic [7:0] d;
      logic signed [9:0] e;
      logic [24:0] r;
      logic [22:0] mant;
      logic up;
      int lz;
      // x carries the larger magnitude, so the result takes its sign
      x = (a[30:0] >= b[30:0]) ? a : b;
      y = (a[30:0] >= b[30:0]) ? b : a;
      mx = (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
      my = (y[30:23] == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
      d = x[30:23] - y[30:23];
      // align smaller operand, folding shifted-out bits into the sticky bit
      ys = (d > 8'd26) ? {26'd0, |my} : ((my >> d) | {26'd0, |(my & ~(27'h7FF_FFFF << d))});
      s = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, ys}) : ({1'b0, mx} - {1'b0, ys});
      if (s == 28'd0) return 32'd0;
      e = {2'b00, x[30:23]};
      if (s[27]) begin
         s = {1'b0, s[27:2], s[1] | s[0]};
         e = e + 10'sd1;
      end else begin
         lz = 0;
         for (int i = 0; i < 27; i++) if (s[i]) lz = 26 - i;
         s = s << lz;
         e = e - 10'(lz);
      end
      up = s[2] & (s[3] | s[1] | s[0]);
      r = {1'b0, s[26:3]} + {24'd0, up};
      mant = r[24] ? r[23:1] : r[22:0];
      e = e + {9'd0, r[24]};
      if (e <= 10'sd0) return 32'd0;
      if (e >= 10'sd255) return {x[31], 8'hFF, 23'd0};
      return {x[31], e[7:0], mant};
   endfunction
   // map a float onto an unsigned key whose integer order matches numeric order
   function automatic logic [31:0] fp_key(input logic [31:0] v);
      return (v[30:23] == 8'd0) ? 32'h8000_0000 : (v[31] ? ~v : {1'b1, v[30:0]});
   endfunction
   function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
      return fp_key(a) >= fp_key(b);
   endfunction
endpackage

// File: rtl/potential_update_scheduler_adder.sv
// potential_adder: integrate a weight into a potential and apply threshold-and-subtract
// Ports: clear (forces outputs to zero), input_weight, decayed_potential, v_threshold
//   (IEEE-754 operands); final_potential (V+W, or V+W-Vth when spiking), spike.
module potential_adder
   import potential_update_scheduler_pkg::*;
(
   input  logic        clear,
   input  logic [31:0] input_weight,
   input  logic [31:0] decayed_potential,
   input  logic [31:0] v_threshold,
   output logic [31:0] final_potential,
   output logic        spike
);
   logic [31:0] sum, rem;
   logic ge;
   assign sum = fp_add(decayed_potential, input_weight);
   assign ge = fp_ge(sum, v_threshold);
   assign rem = fp_add(sum, {~v_threshold[31], v_threshold[30:0]});
   assign spike = !clear && ge;
   assign final_potential = clear ? 32'd0 : (ge ? rem : sum);
endmodule

// File: rtl/potential_update_scheduler.sv
// potential_update_scheduler: per-timestep weight-event integrator with spike output
// Ports: clk, reset (sync, active-high); ts_start/ts_end timestep pulses;
//   w_valid/w_ready/w_id/w_weight weight event input; spike_valid/spike_ready/spike_id
//   spike output; cfg_we/cfg_addr/cfg_data threshold write (IDLE only);
//   rd_addr/rd_potential combinational potential read; busy; ts_done pulse.
module potential_update_scheduler
   import potential_update_scheduler_pkg::*;
#(
   parameter int NUM_NEURONS = DEF_NUM_NEURONS,
   parameter int ID_W = DEF_ID_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ts_start,
   input  logic            ts_end,
   input  logic            w_valid,
   output logic            w_ready,
   input  logic [ID_W-1:0] w_id,
   input  logic [31:0]     w_weight,
   output logic            spike_valid,
   input  logic            spike_ready,
   output logic [ID_W-1:0] spike_id,
   input  logic            cfg_we,
   input  logic [ID_W-1:0] cfg_addr,
   input  logic [31:0]     cfg_data,
   input  logic [ID_W-1:0] rd_addr,
   output logic [31:0]     rd_potential,
   output logic            busy,
   output logic            ts_done
);
   state_t state, state_n;
   logic [31:0] pot [NUM_NEURONS];
   logic [31:0] thr [NUM_NEURONS];
   logic [ID_W-1:0] id_q;
   logic [31:0] weight_q, op_w, op_v, op_th, final_potential;
   logic end_pending, spike;

   potential_adder u_adder (
      .clear(1'b0),
      .input_weight(op_w),
      .decayed_potential(op_v),
      .v_threshold(op_th),
      .final_potential(final_potential),
      .spike(spike)
   );

   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:      state_n = ts_start ? WAIT_EVT : IDLE;
         // a pending close still lets a waiting weight in first
         WAIT_EVT:  state_n = w_valid ? ISSUE : (end_pending ? DONE : WAIT_EVT);
         ISSUE:     state_n = CAPTURE;
         CAPTURE:   state_n = spike ? SPIKE_OUT : WAIT_EVT;
         SPIKE_OUT: state_n = spike_ready ? WAIT_EVT : SPIKE_OUT;
         DONE:      state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (reset) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            pot[i] <= 32'd0;
            thr[i] <= THRESH_RESET;
         end
         id_q <= '0;
         weight_q <= 32'd0;
         op_w <= 32'd0;
         op_v <= 32'd0;
         op_th <= 32'd0;
         end_pending <= 1'b0;
      end else begin
         if (state == IDLE && cfg_we) thr[cfg_addr] <= cfg_data;
         if (state == WAIT_EVT && w_valid) begin
            id_q <= w_id;
            weight_q <= w_weight;
         end
         // operands stay frozen through CAPTURE since only ISSUE loads them
         if (state == ISSUE) begin
            op_w <= weight_q;
            op_v <= pot[id_q];
            op_th <= thr[id_q];
         end
         if (state == CAPTURE) pot[id_q] <= final_potential;
         end_pending <= (state == DONE) ? 1'b0 : (end_pending | (ts_end && state != IDLE));
      end

   assign w_ready = state == WAIT_EVT;
   assign spike_valid = state == SPIKE_OUT;
   assign spike_id = id_q;
   assign busy = state != IDLE;
   assign ts_done = state == DONE;
   assign rd_potential = pot[rd_addr];
endmodule

// File: tb/tb_potential_update_scheduler.sv
// tb_potential_update_scheduler: scoreboard bench with a fixed-point reference model
module tb_potential_update_scheduler;
   localparam int N = 4;
   localparam int IW = 2;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ts_start = 1'b0, ts_end = 1'b0, w_valid = 1'b0, spike_ready = 1'b0, cfg_we = 1'b0;
   logic w_ready, spike_valid, busy, ts_done;
   logic [IW-1:0] w_id = '0, cfg_addr = '0, rd_addr = '0, spike_id;
   logic [31:0] w_weight = 32'd0, cfg_data = 32'd0, rd_potential;
   int errors = 0, checks = 0;
   int pot_m [N];
   int thr_m [N];
   int exp_q [$];
   bit rand_rdy = 1'b0;

   always #5 clk = ~clk;

   potential_update_scheduler #(.NUM_NEURONS(N), .ID_W(IW)) dut (
      .clk(clk), .reset(reset), .ts_start(ts_start), .ts_end(ts_end),
      .w_valid(w_valid), .w_ready(w_ready), .w_id(w_id), .w_weight(w_weight),
      .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_id(spike_id),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .rd_addr(rd_addr), .rd_potential(rd_potential), .busy(busy), .ts_done(ts_done)
   );

   // model values are integers in units of 1/16, always exactly representable
   function automatic logic [31:0] fp(input int q);
      int m, p;
      logic [31:0] r;
      if (q == 0) return 32'd0;
      m = (q < 0) ? -q : q;
      p = 0;
      for (int i = 0; i < 31; i++) if ((m >> i) != 0) p = i;
      r[31] = q < 0;
      r[30:23] = 8'(127 + p - 4);
      r[22:0] = 23'((m << (23 - p)) & 32'h7F_FFFF);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      for (int i = 0; i < N; i++) begin
         pot_m[i] = 0;
         thr_m[i] = 16;
      end
      exp_q.delete();
   endtask

   task automatic model_apply(input int id, input int q);
      int s;
      s = pot_m[id] + q;
      if (s >= thr_m[id]) begin
         exp_q.push_back(id);
         pot_m[id] = s - thr_m[id];
      end else pot_m[id] = s;
   endtask

   task automatic accept(input int id, input int q);
      int n;
      w_valid = 1'b1;
      w_id = IW'(id);
      w_weight = fp(q);
      n = 0;
      while (!w_ready && n < 200) begin
         if (rand_rdy) spike_ready = 1'($urandom_range(0, 1));
         tick;
         n++;
      end
      chk("accept_wait", {31'd0, w_ready}, 32'd1);
      tick;
      w_valid = 1'b0;
   endtask

   task automatic send(input int id, input int q);
      model_apply(id, q);
      accept(id, q);
   endtask

   task automatic start_ts;
      ts_start = 1'b1;
      tick;
      ts_start = 1'b0;
   endtask

   task automatic close_ts;
      int n;
      spike_ready = 1'b1;
      ts_end = 1'b1;
      tick;
      ts_end = 1'b0;
      n = 0;
      while (!ts_done && n < 300) begin
         tick;
         n++;
      end
      chk("ts_done_seen", {31'd0, ts_done}, 32'd1);
      tick;
      chk("idle_after_done", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_all_pots(input string name);
      for (int i = 0; i < N; i++) begin
         rd_addr = IW'(i);
         #1;
         chk(name, rd_potential, fp(pot_m[i]));
      end
   endtask

   // monitor: every spike handshake must match the oldest expected spike
   always @(negedge clk)
      if (!reset && spike_valid && spike_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_spike: got id %0d expected none", spike_id);
         end else chk("spike_id", {30'd0, spike_id}, exp_q.pop_front());
      end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_cnt, first;
      model_reset;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      // reset state
      check_all_pots("reset_pot");
      chk("reset_flags", {28'd0, busy, spike_valid, w_ready, ts_done}, 32'd0);
      chk("reset_spike_id", {30'd0, spike_id}, 32'd0);
      // two 0.75 events to neuron 1, with latency
      start_ts;
      spike_ready = 1'b1;
      rd_addr = 2'd1;
      send(1, 12);
      chk("lat_issue", rd_potential, 32'd0);
      tick;
      chk("lat_capture", rd_potential, 32'd0);
      tick;
      chk("pot1_first", rd_potential, 32'h3F40_0000);
      chk("no_spike_first", {31'd0, spike_valid}, 32'd0);
      send(1, 12);
      tick;
      tick;
      chk("pot1_second", rd_potential, 32'h3F00_0000);
      chk("spike_second", {30'd0, spike_valid, spike_id == 2'd1}, 32'd3);
      tick;
      // spike backpressure
      spike_ready = 1'b0;
      send(1, 12);
      tick;
      tick;
      for (int c = 0; c < 5; c++) begin
         chk("bp_hold", {28'd0, spike_valid, w_ready, spike_id}, 32'h9);
         tick;
      end
      spike_ready = 1'b1;
      chk("bp_release_valid", {31'd0, spike_valid}, 32'd1);
      tick;
      chk("bp_after_handshake", {30'd0, w_ready, spike_valid}, 32'd2);
      chk("pot1_third", rd_potential, 32'h3E80_0000);
      // ts_end together with a weight: weight first, then one ts_done
      model_apply(0, 4);
      w_valid = 1'b1;
      w_id = 2'd0;
      w_weight = fp(4);
      ts_end = 1'b1;
      tick;
      w_valid = 1'b0;
      ts_end = 1'b0;
      done_cnt = 0;
      first = -1;
      for (int c = 1; c <= 12; c++) begin
         if (ts_done) begin
            done_cnt++;
            if (first < 0) first = c;
         end
         tick;
      end
      chk("done_cycle", 32'(first), 32'd4);
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("idle_after_end", {31'd0, busy}, 32'd0);
      rd_addr = 2'd0;
      #1;
      chk("pot0_before_done", rd_potential, 32'h3E80_0000);
      // ts_end in IDLE must not leave a stale close request
      ts_end = 1'b1;
      tick;
      ts_end = 1'b0;
      start_ts;
      for (int c = 0; c < 3; c++) begin
         chk("idle_end_ignored", {30'd0, busy, ts_done}, 32'd2);
         tick;
      end
      close_ts;
      // threshold writes: honoured in IDLE, ignored while running
      cfg_we = 1'b1;
      cfg_addr = 2'd2;
      cfg_data = 32'h4000_0000;
      tick;
      cfg_we = 1'b0;
      thr_m[2] = 32;
      start_ts;
      cfg_we = 1'b1;
      cfg_data = 32'h3F80_0000;
      tick;
      cfg_we = 1'b0;
      rd_addr = 2'd2;
      send(2, 24);
      tick;
      tick;
      chk("pot2_no_spike", rd_potential, 32'h3FC0_0000);
      chk("cfg_ignored_no_spike", {31'd0, spike_valid}, 32'd0);
      send(2, 12);
      tick;
      tick;
      chk("cfg_thr2_spike", {31'd0, spike_valid}, 32'd1);
      chk("pot2_after_spike", rd_potential, 32'h3E80_0000);
      close_ts;
      // randomized timesteps against the model
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < N; i++) begin
            int q;
            q = int'($urandom_range(8, 48));
            cfg_we = 1'b1;
            cfg_addr = IW'(i);
            cfg_data = fp(q);
            thr_m[i] = q;
            tick;
         end
         cfg_we = 1'b0;
         start_ts;
         rand_rdy = 1'b1;
         for (int k = 0; k < 40; k++) send(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 48)) - 24);
         rand_rdy = 1'b0;
         close_ts;
         check_all_pots("rand_pot");
         chk("rand_spikes_drained", 32'(exp_q.size()), 32'd0);
      end
      // reset during CAPTURE abandons the event
      start_ts;
      spike_ready = 1'b1;
      accept(3, 48);
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      model_reset;
      for (int c = 0; c < 6; c++) begin
         chk("post_reset_quiet", {30'd0, busy, spike_valid}, 32'd0);
         tick;
      end
      check_all_pots("post_reset_pot");
      // reset threshold is 1.0 and a sum equal to it spikes to exactly zero
      start_ts;
      send(0, 16);
      tick;
      tick;
      chk("thr_reset_tie_spike", {31'd0, spike_valid}, 32'd1);
      close_ts;
      check_all_pots("final_pot");
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/potential_update_scheduler.md
POTENTIAL_UPDATE_SCHEDULER -- requirements
Module: potential_update_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_NEURONS, default 4, number of neurons whose state is held; ID_W, default 2, neuron-id width, with NUM_NEURONS = 2**ID_W.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ts_start  in  1  one-cycle pulse that opens a timestep
- ts_end  in  1  one-cycle pulse that requests timestep close
- w_valid  in  1  weight event valid
- w_ready  out  1  weight event accepted this cycle when high with w_valid
- w_id  in  ID_W  target neuron of weight event
- w_weight  in  32  IEEE-754 single-precision weight
- spike_valid  out  1  spike event valid
- spike_ready  in  1  downstream accepts spike
- spike_id  out  ID_W  neuron that spiked
- cfg_we  in  1  threshold write enable
- cfg_addr  in  ID_W  threshold write address
- cfg_data  in  32  IEEE-754 threshold value
- rd_addr  in  ID_W  debug potential read address
- rd_potential  out  32  combinational read of stored potential[rd_addr]
- busy  out  1  high in every state except IDLE
- ts_done  out  1  one-cycle pulse when a timestep closes

Function
REQ-003 The block SHALL hold NUM_NEURONS 32-bit potentials and NUM_NEURONS 32-bit thresholds, all IEEE-754.
REQ-004 The FSM states SHALL be IDLE, WAIT_EVT, ISSUE, CAPTURE, SPIKE_OUT, DONE.
REQ-005 IDLE: ts_start -> WAIT_EVT; cfg_we writes threshold[cfg_addr] <= cfg_data, and only in IDLE; cfg_we in any other state is ignored.
REQ-006 w_ready SHALL be high only in WAIT_EVT; on accept in cycle T, id and weight are latched and the FSM enters ISSUE at T+1.
REQ-007 ISSUE (T+1): the adder operands SHALL be registered as input_weight = latched weight, decayed_potential = potential[id], v_threshold = threshold[id], and held stable through CAPTURE.
REQ-008 CAPTURE (T+2): potential[id] SHALL be written with adder final_potential (already V - Vth when spiking); next state is SPIKE_OUT if adder spike = 1, else WAIT_EVT.
REQ-009 SPIKE_OUT: spike_valid = 1, spike_id = latched id, both held stable until spike_ready; on handshake -> WAIT_EVT next cycle.
REQ-010 ts_end in any non-IDLE state SHALL set a sticky end_pending flag; ts_end in IDLE is ignored.
REQ-011 WAIT_EVT with end_pending: if w_valid is high, the weight SHALL be accepted first; otherwise -> DONE.
REQ-012 DONE: ts_done = 1 for exactly one cycle; end_pending cleared; -> IDLE. Potentials persist across timesteps.
REQ-013 ts_start outside IDLE SHALL be ignored.
REQ-014 Back-to-back events to the same neuron SHALL each read the potential written by the previous CAPTURE; there is no hazard because at most one event is in flight.

Reset
REQ-015 On reset: state = IDLE; all potentials = 0x00000000; all thresholds = 0x3F800000 (1.0); end_pending = 0; w_ready, spike_valid, busy, ts_done = 0; spike_id = 0; adder operand registers = 0.
REQ-016 Reset asserted mid-operation SHALL abandon any in-flight event or pending spike without emitting it.

Structure
REQ-017 A shared header SHALL hold the FSM state encodings, the reset threshold constant 0x3F800000, and the default NUM_NEURONS/ID_W.
REQ-018 One sub-module SHALL be instantiated: potential_adder, driven from the operand registers; its clear input is tied low.

Verification
REQ-019 Reset, then read all rd_addr -> every potential 0x00000000; busy = 0, spike_valid = 0.
REQ-020 ts_start; weight 0x3F400000 (0.75) to id 1 twice, spike_ready = 1 -> first accept gives potential[1] = 0x3F400000 and no spike; second gives spike_valid with spike_id = 1 and potential[1] = 0x3F000000 (0.5); per-event latency accept -> write = 2 cycles.
REQ-021 Spike backpressure: spike_ready = 0 for 5 cycles -> spike_valid/spike_id held, w_ready = 0 throughout; release -> w_ready high the cycle after the handshake.
REQ-022 ts_end and w_valid in the same cycle in WAIT_EVT -> weight processed first, then single ts_done pulse, then IDLE.
REQ-023 cfg_we to addr 2 with 0x40000000 (2.0) in IDLE updates threshold; the same write during WAIT_EVT is ignored (weight 1.5 to id 2 after a 2.0 write -> no spike).
REQ-024 Reset asserted in CAPTURE -> potentials return to 0, no spike emitted, state IDLE.
